// File: rtl/cmp_result_monitor_if.sv
// Comparator-flag sample bus between a magnitude comparator and its result monitor.
// Optional err_cnt member is present only with CMP_MON_ERR_CNT_EN.
interface cmp_result_monitor_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             a_gt_b;
    logic             a_eq_b;
    logic             a_lt_b;
    logic             clr_cnt;
    logic             stable_valid;
    logic [1:0]       stable_code;
    logic             stable_change;
    logic             err;
    logic [CNT_W-1:0] gt_cnt;
    logic [CNT_W-1:0] eq_cnt;
    logic [CNT_W-1:0] lt_cnt;
`ifdef CMP_MON_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt;
`endif

    modport master (
        output in_valid, a_gt_b, a_eq_b, a_lt_b, clr_cnt,
        input  stable_valid, stable_code, stable_change, err,
`ifdef CMP_MON_ERR_CNT_EN
        input  err_cnt,
`endif
        input  gt_cnt, eq_cnt, lt_cnt
    );

    modport slave (
        input  in_valid, a_gt_b, a_eq_b, a_lt_b, clr_cnt,
        output stable_valid, stable_code, stable_change, err,
`ifdef CMP_MON_ERR_CNT_EN
        output err_cnt,
`endif
        output gt_cnt, eq_cnt, lt_cnt
    );
endinterface

// File: rtl/cmp_result_monitor.sv
// Debounces comparator flags into a locked result, counts outcomes, flags illegal combos.
// Optional CMP_MON_ERR_CNT_EN adds a saturating counter of illegal samples.
module cmp_result_monitor #(
    parameter int CNT_W   = 8,
    parameter int DEB_LEN = 3
) (
    input logic                 clk,
    input logic                 rst,
    cmp_result_monitor_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_LOCK
    } state_t;

    localparam logic [3:0]       DEB  = 4'(DEB_LEN);
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_run_code;
    logic [1:0]       w_run_code_nxt;
    logic [3:0]       r_run_len;
    logic [3:0]       w_run_len_nxt;
    logic             r_stable_valid;
    logic [1:0]       r_stable_code;
    logic             r_stable_change;
    logic             r_err;
    logic [CNT_W-1:0] r_gt_cnt;
    logic [CNT_W-1:0] r_eq_cnt;
    logic [CNT_W-1:0] r_lt_cnt;
    logic             w_onehot;
    logic             w_legal;
    logic             w_illegal;
    logic [1:0]       w_code;
    logic             w_lock;

    assign w_onehot  = (bus.a_gt_b ^ bus.a_eq_b ^ bus.a_lt_b)
                     & ~(bus.a_gt_b & bus.a_eq_b & bus.a_lt_b);
    assign w_legal   = bus.in_valid & w_onehot;
    assign w_illegal = bus.in_valid & ~w_onehot;
    // One-hot flags map straight onto the code: GT=01, LT=10, EQ=00
    assign w_code    = {bus.a_lt_b, bus.a_gt_b};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_run_code <= 2'b00;
            r_run_len  <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_run_code <= w_run_code_nxt;
            r_run_len  <= w_run_len_nxt;
        end
    end

    always_comb begin
        w_run_code_nxt = r_run_code;
        w_run_len_nxt  = r_run_len;
        if (w_illegal) begin
            w_run_len_nxt = 4'd0;
        end else if (w_legal) begin
            if (r_state != S_IDLE && w_code == r_run_code) begin
                if (r_run_len != DEB)
                    w_run_len_nxt = r_run_len + 4'd1;
            end else begin
                w_run_code_nxt = w_code;
                w_run_len_nxt  = 4'd1;
            end
        end
        if (w_run_len_nxt == 4'd0)
            w_state_nxt = S_IDLE;
        else if (w_run_len_nxt == DEB)
            w_state_nxt = S_LOCK;
        else
            w_state_nxt = S_RUN;
    end

    always_comb begin
        w_lock = 1'b0;
        if (w_legal && w_run_len_nxt == DEB)
            w_lock = !r_stable_valid || (w_run_code_nxt != r_stable_code);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stable_valid  <= 1'b0;
            r_stable_code   <= 2'b00;
            r_stable_change <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            r_stable_change <= w_lock;
            r_err           <= w_illegal;
            if (w_lock) begin
                r_stable_valid <= 1'b1;
                r_stable_code  <= w_run_code_nxt;
            end
        end
    end

    // Clear wins over a same-edge increment; debounce still sees that sample
    always_ff @(posedge clk) begin
        if (rst || bus.clr_cnt) begin
            r_gt_cnt <= '0;
            r_eq_cnt <= '0;
            r_lt_cnt <= '0;
        end else if (w_legal) begin
            if (w_code == 2'b01 && r_gt_cnt != CMAX)
                r_gt_cnt <= r_gt_cnt + 1'b1;
            if (w_code == 2'b00 && r_eq_cnt != CMAX)
                r_eq_cnt <= r_eq_cnt + 1'b1;
            if (w_code == 2'b10 && r_lt_cnt != CMAX)
                r_lt_cnt <= r_lt_cnt + 1'b1;
        end
    end

`ifdef CMP_MON_ERR_CNT_EN
    logic [CNT_W-1:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst || bus.clr_cnt)
            r_err_cnt <= '0;
        else if (w_illegal && r_err_cnt != CMAX)
            r_err_cnt <= r_err_cnt + 1'b1;
    end

    assign bus.err_cnt = r_err_cnt;
`endif

    assign bus.stable_valid  = r_stable_valid;
    assign bus.stable_code   = r_stable_code;
    assign bus.stable_change = r_stable_change;
    assign bus.err           = r_err;
    assign bus.gt_cnt        = r_gt_cnt;
    assign bus.eq_cnt        = r_eq_cnt;
    assign bus.lt_cnt        = r_lt_cnt;
endmodule

// File: tb/tb_cmp_result_monitor.sv
// Directed bench for cmp_result_monitor: CNT_W=8 and CNT_W=2 instances, DEB_LEN=3.
// Both instances see identical stimulus; err_cnt checks follow CMP_MON_ERR_CNT_EN.
module tb_cmp_result_monitor;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    cmp_result_monitor_if #(.CNT_W(8)) b8 ();
    cmp_result_monitor_if #(.CNT_W(2)) b2 ();

    cmp_result_monitor #(.CNT_W(8), .DEB_LEN(3)) u8 (
        .clk (clk),
        .rst (rst),
        .bus (b8.slave)
    );

    cmp_result_monitor #(.CNT_W(2), .DEB_LEN(3)) u2 (
        .clk (clk),
        .rst (rst),
        .bus (b2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic smp(input bit v, input bit g, input bit e,
                       input bit l, input bit c);
        b8.in_valid = v; b8.a_gt_b = g; b8.a_eq_b = e;
        b8.a_lt_b = l; b8.clr_cnt = c;
        b2.in_valid = v; b2.a_gt_b = g; b2.a_eq_b = e;
        b2.a_lt_b = l; b2.clr_cnt = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_rst(input int n);
        rst = 1'b1;
        repeat (n) smp(0, 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_rst(2);
        smp(0, 0, 0, 0, 0);
        checks++; if (b8.stable_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0d exp=0", b8.stable_valid); end
        checks++; if (b8.stable_code !== 2'b00) begin errors++; $display("FAIL rst_code got=%0d exp=0", b8.stable_code); end
        checks++; if (b8.stable_change !== 1'b0) begin errors++; $display("FAIL rst_change got=%0d exp=0", b8.stable_change); end
        checks++; if (b8.err !== 1'b0) begin errors++; $display("FAIL rst_err got=%0d exp=0", b8.err); end
        checks++; if ({b8.gt_cnt, b8.eq_cnt, b8.lt_cnt} !== 24'd0) begin errors++; $display("FAIL rst_cnt got=%0h exp=0", {b8.gt_cnt, b8.eq_cnt, b8.lt_cnt}); end
`ifdef CMP_MON_ERR_CNT_EN
        checks++; if (b8.err_cnt !== 8'd0) begin errors++; $display("FAIL rst_errcnt got=%0d exp=0", b8.err_cnt); end
`endif
    endtask

    task automatic test_lock;
        smp(1, 1, 0, 0, 0);
        smp(1, 1, 0, 0, 0);
        checks++; if (b8.stable_valid !== 1'b0) begin errors++; $display("FAIL lock_early got=%0d exp=0", b8.stable_valid); end
        smp(1, 1, 0, 0, 0);
        checks++; if (b8.stable_valid !== 1'b1) begin errors++; $display("FAIL lock_valid got=%0d exp=1", b8.stable_valid); end
        checks++; if (b8.stable_code !== 2'b01) begin errors++; $display("FAIL lock_code got=%0d exp=1", b8.stable_code); end
        checks++; if (b8.stable_change !== 1'b1) begin errors++; $display("FAIL lock_pulse got=%0d exp=1", b8.stable_change); end
        checks++; if (b8.gt_cnt !== 8'd3) begin errors++; $display("FAIL lock_gtcnt got=%0d exp=3", b8.gt_cnt); end
        smp(1, 1, 0, 0, 0);
        checks++; if (b8.stable_change !== 1'b0) begin errors++; $display("FAIL relock_pulse got=%0d exp=0", b8.stable_change); end
        checks++; if (b8.gt_cnt !== 8'd4) begin errors++; $display("FAIL gtcnt4 got=%0d exp=4", b8.gt_cnt); end
    endtask

    task automatic test_change;
        smp(1, 1, 0, 0, 0);
        smp(1, 1, 0, 0, 0);
        smp(1, 0, 1, 0, 0);
        smp(1, 0, 1, 0, 0);
        checks++; if (b8.stable_code !== 2'b01) begin errors++; $display("FAIL chg_hold got=%0d exp=1", b8.stable_code); end
        checks++; if (b8.stable_change !== 1'b0) begin errors++; $display("FAIL chg_early got=%0d exp=0", b8.stable_change); end
        smp(1, 0, 1, 0, 0);
        checks++; if (b8.stable_code !== 2'b00) begin errors++; $display("FAIL chg_code got=%0d exp=0", b8.stable_code); end
        checks++; if (b8.stable_change !== 1'b1) begin errors++; $display("FAIL chg_pulse got=%0d exp=1", b8.stable_change); end
        checks++; if (b8.eq_cnt !== 8'd3) begin errors++; $display("FAIL chg_eqcnt got=%0d exp=3", b8.eq_cnt); end
        smp(0, 0, 0, 0, 0);
        checks++; if (b8.stable_change !== 1'b0) begin errors++; $display("FAIL chg_one got=%0d exp=0", b8.stable_change); end
    endtask

    task automatic test_illegal;
        do_rst(1);
        smp(1, 1, 0, 0, 0);
        smp(1, 1, 0, 0, 0);
        smp(1, 1, 1, 0, 0);
        checks++; if (b8.err !== 1'b1) begin errors++; $display("FAIL ill_err got=%0d exp=1", b8.err); end
        smp(1, 1, 0, 0, 0);
        checks++; if (b8.err !== 1'b0) begin errors++; $display("FAIL ill_errlen got=%0d exp=0", b8.err); end
        checks++; if (b8.stable_valid !== 1'b0) begin errors++; $display("FAIL ill_nolock got=%0d exp=0", b8.stable_valid); end
        checks++; if ({b8.gt_cnt, b8.eq_cnt, b8.lt_cnt} !== {8'd3, 8'd0, 8'd0}) begin errors++; $display("FAIL ill_cnt got=%0h exp=030000", {b8.gt_cnt, b8.eq_cnt, b8.lt_cnt}); end
`ifdef CMP_MON_ERR_CNT_EN
        checks++; if (b8.err_cnt !== 8'd1) begin errors++; $display("FAIL ill_errcnt got=%0d exp=1", b8.err_cnt); end
`endif
        smp(1, 0, 0, 0, 0);
        checks++; if (b8.err !== 1'b1) begin errors++; $display("FAIL zero_err got=%0d exp=1", b8.err); end
`ifdef CMP_MON_ERR_CNT_EN
        checks++; if (b8.err_cnt !== 8'd2) begin errors++; $display("FAIL zero_errcnt got=%0d exp=2", b8.err_cnt); end
`endif
        smp(0, 1, 1, 1, 0);
        checks++; if (b8.err !== 1'b0) begin errors++; $display("FAIL noval_err got=%0d exp=0", b8.err); end
    endtask

    task automatic test_saturate;
        logic [1:0] exp_lt [5];
        exp_lt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_rst(1);
        for (int i = 0; i < 5; i++) begin
            smp(1, 0, 0, 1, 0);
            checks++; if (b2.lt_cnt !== exp_lt[i]) begin errors++; $display("FAIL sat_lt%0d got=%0d exp=%0d", i, b2.lt_cnt, exp_lt[i]); end
        end
        checks++; if (b8.lt_cnt !== 8'd5) begin errors++; $display("FAIL sat_lt8 got=%0d exp=5", b8.lt_cnt); end
        smp(1, 0, 0, 1, 1);
        checks++; if (b2.lt_cnt !== 2'd0) begin errors++; $display("FAIL clr_lt got=%0d exp=0", b2.lt_cnt); end
        checks++; if (b8.lt_cnt !== 8'd0) begin errors++; $display("FAIL clr_lt8 got=%0d exp=0", b8.lt_cnt); end
        checks++; if ({b2.stable_valid, b2.stable_code} !== 3'b110) begin errors++; $display("FAIL clr_stable got=%0b exp=110", {b2.stable_valid, b2.stable_code}); end
        smp(1, 0, 0, 1, 0);
        checks++; if (b2.lt_cnt !== 2'd1) begin errors++; $display("FAIL clr_resume got=%0d exp=1", b2.lt_cnt); end
    endtask

    task automatic test_rst_mid;
        smp(1, 0, 1, 0, 0);
        smp(1, 0, 0, 1, 0);
        smp(1, 0, 0, 1, 0);
        rst = 1'b1;
        smp(1, 0, 0, 1, 0);
        rst = 1'b0;
        checks++; if ({b8.stable_valid, b8.stable_code, b8.stable_change, b8.err} !== 5'd0) begin errors++; $display("FAIL mid_rst got=%0b exp=0", {b8.stable_valid, b8.stable_code, b8.stable_change, b8.err}); end
        checks++; if ({b8.gt_cnt, b8.eq_cnt, b8.lt_cnt} !== 24'd0) begin errors++; $display("FAIL mid_cnt got=%0h exp=0", {b8.gt_cnt, b8.eq_cnt, b8.lt_cnt}); end
        smp(1, 0, 0, 1, 0);
        smp(1, 0, 0, 1, 0);
        checks++; if (b8.stable_valid !== 1'b0) begin errors++; $display("FAIL mid_early got=%0d exp=0", b8.stable_valid); end
        smp(1, 0, 0, 1, 0);
        checks++; if ({b8.stable_valid, b8.stable_code, b8.stable_change} !== 4'b1101) begin errors++; $display("FAIL mid_relock got=%0b exp=1101", {b8.stable_valid, b8.stable_code, b8.stable_change}); end
    endtask

    task automatic test_gaps;
        do_rst(1);
        smp(1, 1, 0, 0, 0);
        smp(0, 0, 0, 0, 0);
        smp(1, 1, 0, 0, 0);
        smp(0, 0, 1, 0, 0);
        checks++; if (b8.stable_valid !== 1'b0) begin errors++; $display("FAIL gap_early got=%0d exp=0", b8.stable_valid); end
        smp(1, 1, 0, 0, 0);
        checks++; if ({b8.stable_valid, b8.stable_code, b8.stable_change} !== 4'b1011) begin errors++; $display("FAIL gap_lock got=%0b exp=1011", {b8.stable_valid, b8.stable_code, b8.stable_change}); end
        checks++; if (b8.gt_cnt !== 8'd3) begin errors++; $display("FAIL gap_cnt got=%0d exp=3", b8.gt_cnt); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        test_reset();
        test_lock();
        test_change();
        test_illegal();
        test_saturate();
        test_rst_mid();
        test_gaps();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
